// File: rtl/apb2axi_pkg.sv
// apb2axi_pkg: shared state encoding and AXI response codes for the
// APB-slave to AXI4-Lite-master bridge.
package apb2axi_pkg;

  // One-hot bit positions of the bridge FSM
  localparam int ST_IDLE  = 0;
  localparam int ST_WREQ  = 1;
  localparam int ST_WRESP = 2;
  localparam int ST_RREQ  = 3;
  localparam int ST_RDATA = 4;
  localparam int ST_DONE  = 5;

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_WREQ  = 6'b000010,
    S_WRESP = 6'b000100,
    S_RREQ  = 6'b001000,
    S_RDATA = 6'b010000,
    S_DONE  = 6'b100000
  } state_t;

  // AXI BRESP/RRESP encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // SLVERR and DECERR both carry resp[1]; OKAY/EXOKAY do not
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/apb2axi.sv
// apb2axi: APB slave -> AXI4-Lite master bridge, one outstanding transfer.
// Each APB setup phase is latched and replayed as one AXI read or write;
// pready is held low until the AXI response has been taken.
// Optional feature macro: APB2AXI_PSLVERR_EN (report SLVERR/DECERR on pslverr).
module apb2axi
  import apb2axi_pkg::*;
#(
  parameter int          APB_ADRW = 12,
  parameter logic [31:0] AXI_BASE = 32'h8000_0000
) (
  input  logic                aclk,
  input  logic                areset,
  // APB slave port
  input  logic                i_psel,
  input  logic                i_penable,
  input  logic [APB_ADRW-1:0] i_paddr,
  input  logic                i_pwrite,
  input  logic [31:0]         i_pwdata,
  output logic [31:0]         o_prdata,
  output logic                o_pready,
  output logic                o_pslverr,
  // AXI4-Lite master port
  output logic                o_awvalid,
  output logic [31:0]         o_awaddr,
  output logic [2:0]          o_awprot,
  input  logic                i_awready,
  output logic                o_wvalid,
  output logic [31:0]         o_wdata,
  output logic [3:0]          o_wstrb,
  input  logic                i_wready,
  input  logic                i_bvalid,
  input  logic [1:0]          i_bresp,
  output logic                o_bready,
  output logic                o_arvalid,
  output logic [31:0]         o_araddr,
  output logic [2:0]          o_arprot,
  input  logic                i_arready,
  input  logic                i_rvalid,
  input  logic [31:0]         i_rdata,
  input  logic [1:0]          i_rresp,
  output logic                o_rready
);

  localparam logic [31:0] ADDR_MASK = (32'h1 << APB_ADRW) - 32'h1;

  state_t              r_state;
  logic [APB_ADRW-1:0] r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_prdata;
  logic                r_aw_done;
  logic                r_w_done;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_pready;

  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_aw_fin;
  logic                w_w_fin;
  logic [31:0]         w_axi_addr;

  // A channel counts as finished once its flag is set or it handshakes now,
  // so AW and W completing on the same edge still leave WREQ together.
  assign w_aw_hs    = r_awvalid & i_awready;
  assign w_w_hs     = r_wvalid & i_wready;
  assign w_aw_fin   = r_aw_done | w_aw_hs;
  assign w_w_fin    = r_w_done | w_w_hs;
  assign w_axi_addr = (AXI_BASE & ~ADDR_MASK) | {{(32-APB_ADRW){1'b0}}, r_addr};

  // Payloads come only from latched registers, so they stay stable under valid
  assign o_awvalid = r_awvalid;
  assign o_awaddr  = w_axi_addr;
  assign o_awprot  = 3'b000;
  assign o_wvalid  = r_wvalid;
  assign o_wdata   = r_wdata;
  assign o_wstrb   = 4'hF;
  assign o_bready  = r_bready;
  assign o_arvalid = r_arvalid;
  assign o_araddr  = w_axi_addr;
  assign o_arprot  = 3'b000;
  assign o_rready  = r_rready;
  assign o_pready  = r_pready;
  assign o_prdata  = r_prdata;

`ifdef APB2AXI_PSLVERR_EN
  logic [1:0] r_resp;

  // Capture the AXI response code as the transfer enters DONE
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_resp <= RESP_OKAY;
    end else if (r_state == S_WRESP && i_bvalid) begin
      r_resp <= i_bresp;
    end else if (r_state == S_RDATA && i_rvalid) begin
      r_resp <= i_rresp;
    end else begin
      r_resp <= r_resp;
    end
  end

  // r_pready is high exactly during DONE, so pslverr is a one-cycle pulse too
  assign o_pslverr = r_pready & resp_is_err(r_resp);
`else
  logic w_resp_unused;

  assign w_resp_unused = ^{i_bresp, i_rresp};
  assign o_pslverr     = 1'b0;
`endif

  // Bridge FSM: latches the APB request, sequences the AXI channels, pulses pready
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= 32'h0;
      r_prdata  <= 32'h0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_pready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_psel && !i_penable) begin
            r_addr  <= i_paddr;
            r_wdata <= i_pwdata;
            if (i_pwrite) begin
              r_state   <= S_WREQ;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= S_RREQ;
              r_arvalid <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_WREQ: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_state   <= S_WRESP;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b1;
          end else begin
            r_state <= S_WREQ;
          end
        end

        S_WRESP: begin
          if (i_bvalid) begin
            r_state  <= S_DONE;
            r_bready <= 1'b0;
            r_pready <= 1'b1;
          end else begin
            r_state <= S_WRESP;
          end
        end

        S_RREQ: begin
          if (i_arready) begin
            r_state   <= S_RDATA;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end else begin
            r_state <= S_RREQ;
          end
        end

        S_RDATA: begin
          if (i_rvalid) begin
            r_state  <= S_DONE;
            r_prdata <= i_rdata;
            r_rready <= 1'b0;
            r_pready <= 1'b1;
          end else begin
            r_state <= S_RDATA;
          end
        end

        S_DONE: begin
          r_state  <= S_IDLE;
          r_pready <= 1'b0;
        end

        default: begin
          r_state   <= S_IDLE;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
          r_bready  <= 1'b0;
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
          r_pready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb2axi.sv
// tb_apb2axi: table-driven bench for apb2axi with a delay-programmable
// AXI4-Lite slave model and hand-written reset / protocol-violation sequences.
module tb_apb2axi;

  logic        aclk = 1'b0;
  logic        areset;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] o_prdata;
  logic        o_pready, o_pslverr;
  logic        o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready;
  logic [31:0] o_awaddr, o_wdata, o_araddr;
  logic [2:0]  o_awprot, o_arprot;
  logic [3:0]  o_wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  always #5 aclk = ~aclk;

  apb2axi dut (
    .aclk(aclk), .areset(areset),
    .i_psel(psel), .i_penable(penable), .i_paddr(paddr), .i_pwrite(pwrite),
    .i_pwdata(pwdata), .o_prdata(o_prdata), .o_pready(o_pready), .o_pslverr(o_pslverr),
    .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .o_awprot(o_awprot), .i_awready(awready),
    .o_wvalid(o_wvalid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .i_wready(wready),
    .i_bvalid(bvalid), .i_bresp(bresp), .o_bready(o_bready),
    .o_arvalid(o_arvalid), .o_araddr(o_araddr), .o_arprot(o_arprot), .i_arready(arready),
    .i_rvalid(rvalid), .i_rdata(rdata), .i_rresp(rresp), .o_rready(o_rready)
  );

  // slave configuration, owned by the test process
  int          aw_d, w_d, ar_d, b_d, r_d;
  logic [31:0] s_rdata;
  logic [1:0]  s_resp;

  // handshake monitor state, owned by the posedge monitor
  int          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  int          stab_err, order_err;
  logic        aw_pend, w_pend, ar_pend;
  logic [31:0] aw_hold, w_hold, ar_hold;

  // slave-model counters, owned by the negedge slave
  int          cnt_aw, cnt_w, cnt_ar, cnt_b, cnt_r;

  int          checks, errors;

  // result of the last APB transfer, owned by the test process
  int          res_cyc;
  logic [31:0] res_prdata;
  logic        res_perr;
  logic [19:0] res_hs;

  initial begin
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    stab_err = 0; order_err = 0;
    aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0;
    aw_hold = 32'h0; w_hold = 32'h0; ar_hold = 32'h0;
    cap_awaddr = 32'h0; cap_wdata = 32'h0; cap_araddr = 32'h0;
  end

  // Monitor: counts handshakes per transfer, checks payload stability and W-before-B ordering
  always @(posedge aclk) begin
    if (aw_pend && (!o_awvalid || o_awaddr !== aw_hold)) stab_err++;
    if (w_pend && (!o_wvalid || o_wdata !== w_hold)) stab_err++;
    if (ar_pend && (!o_arvalid || o_araddr !== ar_hold)) stab_err++;
    aw_pend = o_awvalid && !awready && !areset; aw_hold = o_awaddr;
    w_pend  = o_wvalid && !wready && !areset;   w_hold  = o_wdata;
    ar_pend = o_arvalid && !arready && !areset; ar_hold = o_araddr;
    if (!areset && o_bready && (aw_hs == 0 || w_hs == 0)) order_err++;
    if (areset || o_pready) begin
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    end else begin
      if (o_awvalid && awready) begin aw_hs++; cap_awaddr = o_awaddr; end
      if (o_wvalid && wready) begin w_hs++; cap_wdata = o_wdata; end
      if (bvalid && o_bready) b_hs++;
      if (o_arvalid && arready) begin ar_hs++; cap_araddr = o_araddr; end
      if (rvalid && o_rready) r_hs++;
    end
  end

  // AXI slave model: each ready/valid asserts after its programmed delay
  always @(negedge aclk) begin
    if (areset) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
      cnt_aw = 0; cnt_w = 0; cnt_ar = 0; cnt_b = 0; cnt_r = 0;
    end else begin
      if (!o_awvalid) begin awready = 1'b0; cnt_aw = 0; end
      else if (cnt_aw == aw_d) awready = 1'b1;
      else begin awready = 1'b0; cnt_aw++; end
      if (!o_wvalid) begin wready = 1'b0; cnt_w = 0; end
      else if (cnt_w == w_d) wready = 1'b1;
      else begin wready = 1'b0; cnt_w++; end
      if (!o_arvalid) begin arready = 1'b0; cnt_ar = 0; end
      else if (cnt_ar == ar_d) arready = 1'b1;
      else begin arready = 1'b0; cnt_ar++; end
      if (!(aw_hs > 0 && w_hs > 0 && b_hs == 0)) begin bvalid = 1'b0; cnt_b = 0; end
      else if (cnt_b == b_d) bvalid = 1'b1;
      else begin bvalid = 1'b0; cnt_b++; end
      if (!(ar_hs > 0 && r_hs == 0)) begin rvalid = 1'b0; cnt_r = 0; end
      else if (cnt_r == r_d) rvalid = 1'b1;
      else begin rvalid = 1'b0; cnt_r++; end
    end
    bresp = bvalid ? s_resp : 2'b00;
    rresp = rvalid ? s_resp : 2'b00;
    rdata = rvalid ? s_rdata : 32'h0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One APB transfer starting at a negedge; leaves the bus idle at the next negedge
  task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd);
    int c;
    bit got;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(negedge aclk);
    penable = 1'b1;
    c = 1;
    got = 1'b0;
    while (!got && c < 60) begin
      if (o_pready) begin
        got = 1'b1;
        res_cyc = c;
        res_prdata = o_prdata;
        res_perr = o_pslverr;
        res_hs = {4'(aw_hs), 4'(w_hs), 4'(b_hs), 4'(ar_hs), 4'(r_hs)};
      end else begin
        @(negedge aclk);
        c++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout: no pready within %0d cycles for addr %0h", c, addr);
      res_cyc = -1;
      res_hs = 20'h0;
      areset = 1'b1;
      @(negedge aclk);
      areset = 1'b0;
    end
    @(negedge aclk);
    psel = 1'b0;
    penable = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          aw_d, w_d, ar_d, b_d, r_d;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [31:0] exp_addr;
    logic [31:0] exp_prdata;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic exp_perr;
    int   pulses, pcyc;
    logic [11:0] c_hs;
    bit   saw;

    checks = 0; errors = 0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 12'h0; pwdata = 32'h0;
    aw_d = 0; w_d = 0; ar_d = 0; b_d = 0; r_d = 0; s_rdata = 32'h0; s_resp = 2'b00;

    vecs[0] = '{1'b1, 12'h010, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h0, 2'b00, 32'h80000010, 32'h00000000, 1'b0, 3};
    vecs[1] = '{1'b0, 12'hFFC, 32'h0, 0, 0, 3, 0, 2, 32'h12345678, 2'b00, 32'h80000FFC, 32'h12345678, 1'b0, 8};
    vecs[2] = '{1'b1, 12'h020, 32'h000000A5, 2, 0, 0, 0, 0, 32'h0, 2'b00, 32'h80000020, 32'h12345678, 1'b0, 5};
    vecs[3] = '{1'b1, 12'h024, 32'h0000005A, 0, 2, 0, 1, 0, 32'h0, 2'b00, 32'h80000024, 32'h12345678, 1'b0, 6};
    vecs[4] = '{1'b0, 12'h000, 32'h0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 2'b10, 32'h80000000, 32'hCAFEF00D, 1'b1, 3};
    vecs[5] = '{1'b1, 12'hABC, 32'h01020304, 0, 0, 0, 0, 0, 32'h0, 2'b00, 32'h80000ABC, 32'hCAFEF00D, 1'b0, 3};
    vecs[6] = '{1'b1, 12'h7F0, 32'hFFFFFFFF, 1, 1, 0, 2, 0, 32'h0, 2'b11, 32'h800007F0, 32'hCAFEF00D, 1'b1, 6};
    vecs[7] = '{1'b0, 12'h444, 32'h0, 0, 0, 1, 0, 1, 32'h5A5A5A5A, 2'b01, 32'h80000444, 32'h5A5A5A5A, 1'b0, 5};

    // reset state
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst_axi_ctrl", {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready}, 5'b00000);
    chk("rst_pready", o_pready, 1'b0);
    chk("rst_pslverr", o_pslverr, 1'b0);
    chk("rst_prdata", o_prdata, 32'h0);
    areset = 1'b0;
    @(negedge aclk);

    // table-driven back-to-back transfers
    for (int i = 0; i < 8; i++) begin
      aw_d = vecs[i].aw_d; w_d = vecs[i].w_d; ar_d = vecs[i].ar_d;
      b_d = vecs[i].b_d; r_d = vecs[i].r_d;
      s_rdata = vecs[i].rdata; s_resp = vecs[i].resp;
`ifdef APB2AXI_PSLVERR_EN
      exp_perr = vecs[i].exp_err;
`else
      exp_perr = 1'b0;
`endif
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("v%0d_cycles", i), 64'(res_cyc), 64'(vecs[i].exp_cyc));
      chk($sformatf("v%0d_prdata", i), res_prdata, vecs[i].exp_prdata);
      chk($sformatf("v%0d_pslverr", i), res_perr, exp_perr);
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_awaddr", i), cap_awaddr, vecs[i].exp_addr);
        chk($sformatf("v%0d_wdata", i), cap_wdata, vecs[i].wdata);
        chk($sformatf("v%0d_hs_aw_w_b_ar_r", i), res_hs, 20'h11100);
      end else begin
        chk($sformatf("v%0d_araddr", i), cap_araddr, vecs[i].exp_addr);
        chk($sformatf("v%0d_hs_aw_w_b_ar_r", i), res_hs, 20'h00011);
      end
    end

    // reset while waiting in RDATA
    aw_d = 0; w_d = 0; ar_d = 0; b_d = 0; r_d = 20; s_resp = 2'b00; s_rdata = 32'h11111111;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h100;
    @(negedge aclk);
    penable = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 10 && !saw; k++) begin
      @(negedge aclk);
      if (o_rready) saw = 1'b1;
    end
    chk("rdata_reached", saw, 1'b1);
    areset = 1'b1;
    @(negedge aclk);
    chk("midrst_rready", o_rready, 1'b0);
    chk("midrst_pready", o_pready, 1'b0);
    chk("midrst_prdata", o_prdata, 32'h0);
    chk("midrst_arvalid", o_arvalid, 1'b0);
    areset = 1'b0; psel = 1'b0; penable = 1'b0; r_d = 0;
    @(negedge aclk);
    xfer(1'b1, 12'h0C0, 32'h0BADF00D);
    chk("postrst_cycles", 64'(res_cyc), 64'd3);
    chk("postrst_awaddr", cap_awaddr, 32'h800000C0);
    chk("postrst_wdata", cap_wdata, 32'h0BADF00D);
    chk("postrst_hs", res_hs, 20'h11100);

    // psel dropped during WREQ
    aw_d = 1; w_d = 1; b_d = 0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h200; pwdata = 32'h55AA55AA;
    pulses = 0; pcyc = 0; c_hs = 12'h0;
    for (int i = 1; i < 16; i++) begin
      @(negedge aclk);
      if (i == 1) begin psel = 1'b0; penable = 1'b0; end
      if (o_pready) begin
        pulses++;
        if (pulses == 1) begin
          pcyc = i;
          c_hs = {4'(aw_hs), 4'(w_hs), 4'(b_hs)};
        end
      end
    end
    chk("drop_done_pulses", 64'(pulses), 64'd1);
    chk("drop_done_cycle", 64'(pcyc), 64'd4);
    chk("drop_hs_aw_w_b", c_hs, 12'h111);
    chk("drop_wdata", cap_wdata, 32'h55AA55AA);
    aw_d = 0; w_d = 0; s_rdata = 32'h0F0F0F0F; s_resp = 2'b00;
    xfer(1'b0, 12'h208, 32'h0);
    chk("after_drop_cycles", 64'(res_cyc), 64'd3);
    chk("after_drop_prdata", res_prdata, 32'h0F0F0F0F);

    chk("payload_stable", 64'(stab_err), 64'd0);
    chk("wresp_after_both", 64'(order_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
